// File: rtl/bus_port_agent.sv
// bus_port_agent: device-side agent for one port of the 3-port parallel bus.
// TX path queues device words, frames them as {dest, src, payload} and pushes
// them into the bus input FIFO no faster than once every PUSH_GAP cycles
// (that FIFO has no full flag). RX path pops packets addressed to this port
// (or broadcast) into a holding register presented on a valid/ready handshake.
//
// Handshakes: a word moves on tx_valid/tx_ready (device -> agent) and on
// rx_valid/rx_ready (agent -> device) only in a cycle where both are high at
// the rising clock edge; a valid, once raised, keeps its data stable until
// accepted.
//
// Optional build macro BUS_AGENT_STATS_EN: when defined, saturating 16-bit
// statistics counters drive stat_tx/stat_rx/stat_drop; otherwise those ports
// are tied to zero.
module bus_port_agent #(
    parameter int         BITS      = 65,
    parameter logic [2:0] DEV_ID    = 3'd0,
    parameter logic [2:0] BROADCAST = 3'b111,
    parameter int         TXQ_DEPTH = 4,
    parameter int         PUSH_GAP  = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [2:0]      tx_dest,
    input  logic [BITS-7:0] tx_payload,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [2:0]      rx_src,
    output logic            rx_bcast,
    output logic [BITS-7:0] rx_payload,
    output logic            err_misroute,
    output logic            bus_push,
    output logic [BITS-1:0] bus_d_push,
    input  logic            bus_pndng,
    output logic            bus_pop,
    input  logic [BITS-1:0] bus_d_pop,
    output logic [15:0]     stat_tx,
    output logic [15:0]     stat_rx,
    output logic [15:0]     stat_drop
);

    localparam int PW = BITS - 6;
    localparam int AW = $clog2(TXQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (PUSH_GAP > 1) ? $clog2(PUSH_GAP) : 1;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_PUSH = 2'd1,
        T_GAP  = 2'd2
    } tx_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_HOLD = 1'b1
    } rx_state_e;

    // ------------------------------------------------------------------
    // TX queue
    // ------------------------------------------------------------------
    logic [BITS-1:0] txq_mem_q [TXQ_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   txq_cnt_q, txq_cnt_d;
    logic            txq_full, txq_empty;
    logic            txq_enq, txq_deq;
    logic [BITS-1:0] txq_head;

    tx_state_e       tx_state_q, tx_state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            bus_push_q, bus_push_d;
    logic [BITS-1:0] bus_d_push_q, bus_d_push_d;

    assign txq_full  = (txq_cnt_q == CW'(TXQ_DEPTH));
    assign txq_empty = (txq_cnt_q == '0);
    assign tx_ready  = !txq_full;
    assign txq_enq   = tx_valid && !txq_full;
    // The head leaves the queue in the cycle its bus_push pulse is visible.
    assign txq_deq   = (tx_state_q == T_PUSH) && !txq_empty;
    assign txq_head  = txq_mem_q[rd_ptr_q];

    // Queue storage: written on accept, no reset needed for the data array.
    always_ff @(posedge clk) begin
        if (txq_enq) begin
            txq_mem_q[wr_ptr_q] <= {tx_dest, DEV_ID, tx_payload};
        end
    end

    // Next pointer/occupancy values; power-of-2 depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        txq_cnt_d = txq_cnt_q;
        if (txq_enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (txq_deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({txq_enq, txq_deq})
            2'b10:   txq_cnt_d = txq_cnt_q + CW'(1);
            2'b01:   txq_cnt_d = txq_cnt_q - CW'(1);
            default: txq_cnt_d = txq_cnt_q;
        endcase
    end

    // Queue pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            txq_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            txq_cnt_q <= txq_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: the push pulse is registered, so it is launched on the edge
    // that enters T_PUSH. The gap counter is loaded with PUSH_GAP-1 when
    // leaving T_PUSH; the next push is launched when it would reach zero,
    // which spaces consecutive pulses exactly PUSH_GAP cycles apart.
    // ------------------------------------------------------------------
    // TX next-state and registered push outputs.
    always_comb begin
        tx_state_d   = tx_state_q;
        gap_d        = gap_q;
        bus_push_d   = 1'b0;
        bus_d_push_d = bus_d_push_q;
        case (tx_state_q)
            T_IDLE: begin
                if (!txq_empty) begin
                    bus_push_d   = 1'b1;
                    bus_d_push_d = txq_head;
                    tx_state_d   = T_PUSH;
                end
            end
            T_PUSH: begin
                if (PUSH_GAP == 1) begin
                    tx_state_d = T_IDLE;
                end else begin
                    gap_d      = GW'(PUSH_GAP - 1);
                    tx_state_d = T_GAP;
                end
            end
            T_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    gap_d = '0;
                    if (!txq_empty) begin
                        bus_push_d   = 1'b1;
                        bus_d_push_d = txq_head;
                        tx_state_d   = T_PUSH;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end
            end
            default: begin
                tx_state_d = T_IDLE;
                gap_d      = '0;
            end
        endcase
    end

    // TX state, gap counter and push output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= T_IDLE;
            gap_q        <= '0;
            bus_push_q   <= 1'b0;
            bus_d_push_q <= '0;
        end else begin
            tx_state_q   <= tx_state_d;
            gap_q        <= gap_d;
            bus_push_q   <= bus_push_d;
            bus_d_push_q <= bus_d_push_d;
        end
    end

    assign bus_push   = bus_push_q;
    assign bus_d_push = bus_d_push_q;

    // ------------------------------------------------------------------
    // RX FSM: pop only while idle; the popped word is decoded in the same
    // cycle and either captured in the holding register or dropped.
    // ------------------------------------------------------------------
    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_valid_q, rx_valid_d;
    logic [2:0]      rx_src_q, rx_src_d;
    logic            rx_bcast_q, rx_bcast_d;
    logic [PW-1:0]   rx_payload_q, rx_payload_d;
    logic            misroute_q, misroute_d;
    logic [2:0]      pkt_dest;
    logic [2:0]      pkt_src;
    logic [PW-1:0]   pkt_payload;
    logic            pkt_for_us;

    assign pkt_dest    = bus_d_pop[BITS-1:BITS-3];
    assign pkt_src     = bus_d_pop[BITS-4:BITS-6];
    assign pkt_payload = bus_d_pop[BITS-7:0];
    assign pkt_for_us  = (pkt_dest == DEV_ID) || (pkt_dest == BROADCAST);

    // Gated by rst so no pop can leak out while the agent is held in reset.
    assign bus_pop = (rx_state_q == R_IDLE) && bus_pndng && !rst;

    // RX next-state, holding register and misroute pulse.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_valid_d   = rx_valid_q;
        rx_src_d     = rx_src_q;
        rx_bcast_d   = rx_bcast_q;
        rx_payload_d = rx_payload_q;
        misroute_d   = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (bus_pop) begin
                    if (pkt_for_us) begin
                        rx_valid_d   = 1'b1;
                        rx_src_d     = pkt_src;
                        rx_bcast_d   = (pkt_dest == BROADCAST);
                        rx_payload_d = pkt_payload;
                        rx_state_d   = R_HOLD;
                    end else begin
                        misroute_d = 1'b1;
                    end
                end
            end
            R_HOLD: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    rx_state_d = R_IDLE;
                end
            end
            default: begin
                rx_valid_d = 1'b0;
                rx_state_d = R_IDLE;
            end
        endcase
    end

    // RX state and holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q   <= R_IDLE;
            rx_valid_q   <= 1'b0;
            rx_src_q     <= '0;
            rx_bcast_q   <= 1'b0;
            rx_payload_q <= '0;
            misroute_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_valid_q   <= rx_valid_d;
            rx_src_q     <= rx_src_d;
            rx_bcast_q   <= rx_bcast_d;
            rx_payload_q <= rx_payload_d;
            misroute_q   <= misroute_d;
        end
    end

    assign rx_valid     = rx_valid_q;
    assign rx_src       = rx_src_q;
    assign rx_bcast     = rx_bcast_q;
    assign rx_payload   = rx_payload_q;
    assign err_misroute = misroute_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BUS_AGENT_STATS_EN
    logic [15:0] stat_tx_q, stat_rx_q, stat_drop_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_tx_q   <= '0;
            stat_rx_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            if (bus_push_q && (stat_tx_q != 16'hFFFF)) begin
                stat_tx_q <= stat_tx_q + 16'd1;
            end
            if (rx_valid_q && rx_ready && (stat_rx_q != 16'hFFFF)) begin
                stat_rx_q <= stat_rx_q + 16'd1;
            end
            if (misroute_q && (stat_drop_q != 16'hFFFF)) begin
                stat_drop_q <= stat_drop_q + 16'd1;
            end
        end
    end

    assign stat_tx   = stat_tx_q;
    assign stat_rx   = stat_rx_q;
    assign stat_drop = stat_drop_q;
`else
    assign stat_tx   = 16'd0;
    assign stat_rx   = 16'd0;
    assign stat_drop = 16'd0;
`endif

endmodule
